dmem_uart_mmio: RTL and testbench

//  Data-side memory subsystem fed directly by the single-cycle cpu's daddr/dwdata/dwe and returning drdata.

---
 rtl/dmem_uart_mmio_if.sv | 11 +
 rtl/dmem_uart_mmio.sv | 189 ++++++++++++++++++
 tb/tb_dmem_uart_mmio.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_uart_mmio_if.sv
// CPU data-side bus into the data memory / UART block.
// No valid/ready: every cycle is a transfer, dwe!=0 commits a store at the next clk edge, and drdata is combinational from daddr.
interface dmem_uart_mmio_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  modport master (output daddr, output dwdata, output dwe, input drdata);
  modport slave  (input daddr, input dwdata, input dwe, output drdata);
endinterface

// File: rtl/dmem_uart_mmio.sv
// Byte-writable data RAM plus memory-mapped UART transmitter (TX FIFO + serializer).
// Define UART_IRQ_EN to add the IRQCTL register and the uart_irq output.
module dmem_uart_mmio #(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] UART_BASE    = 32'h4000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_uart_mmio_if.slave  bus,
  output logic [1:0]       fsm_state,
  output logic             uart_tx
`ifdef UART_IRQ_EN
  , output logic           uart_irq
`endif
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_tx, sel_stat;
  logic [PW:0]   count;
  logic          empty, full, busy, pop, push_req, push_ok, tick;
  logic [7:0]    head;
  logic [31:0]   status_word;
  logic          unused_addr_lsbs;

  assign word_addr        = bus.daddr[31:2];
  assign ram_idx          = bus.daddr[AW+1:2];
  assign sel_ram          = word_addr < 30'(MEM_WORDS);
  assign sel_tx           = word_addr == UART_BASE[31:2];
  assign sel_stat         = word_addr == UART_BASE[31:2] + 30'd1;
  assign unused_addr_lsbs = ^bus.daddr[1:0];

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign head     = fifo_mem[rd_ptr_q[PW-1:0]];
  assign busy     = (state_q != S_IDLE);
  assign tick     = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign push_req = sel_tx && bus.dwe[0];
  // A full FIFO still accepts when the serializer pops on the same edge.
  assign push_ok  = push_req && (!full || pop);

  // Bit 5 is reserved so that empty sits at bit 4 and ovf at bit 8.
  assign status_word = {23'b0, ovf_q, busy, full, 1'b0, empty, 4'(count)};
  assign fsm_state   = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        uart_tx = 1'b0;
        if (tick) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        uart_tx = shift_q[0];
        if (tick) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (sel_stat && bus.dwe[0] && bus.dwdata[8]) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

`ifdef UART_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d, sel_irq;
  assign sel_irq  = word_addr == UART_BASE[31:2] + 30'd2;
  assign uart_irq = irq_q;

  always_comb begin
    ie_d  = ie_q;
    irq_d = ie_q && empty && (state_q == S_IDLE);
    if (sel_irq && bus.dwe[0]) ie_d = bus.dwdata[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end
`endif

  always_comb begin
    bus.drdata = '0;
    if (sel_ram)       bus.drdata = ram[ram_idx];
    else if (sel_stat) bus.drdata = status_word;
`ifdef UART_IRQ_EN
    else if (sel_irq)  bus.drdata = {31'b0, ie_q};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset: RAM survives reset, FIFO slots are guarded by the pointers.
  always_ff @(posedge clk) begin
    if (sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dwe[i]) ram[ram_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
      end
    end
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= bus.dwdata[7:0];
  end
endmodule

// File: tb/tb_dmem_uart_mmio.sv
// Directed bench for dmem_uart_mmio: RAM/decode vector table plus hand-written UART frame sequences.
module tb_dmem_uart_mmio;
  localparam int          CPB    = 4;
  localparam logic [31:0] TXDATA = 32'h4000_0000;
  localparam logic [31:0] STATUS = 32'h4000_0004;
  localparam logic [31:0] IRQCTL = 32'h4000_0008;

  logic       clk;
  logic       reset;
  logic       uart_tx;
  logic [1:0] fsm_state;
`ifdef UART_IRQ_EN
  logic       uart_irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  dmem_uart_mmio_if bus ();

  dmem_uart_mmio #(
    .MEM_WORDS(1024), .UART_BASE(32'h4000_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fsm_state(fsm_state),
    .uart_tx(uart_tx)
`ifdef UART_IRQ_EN
    , .uart_irq(uart_irq)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver: store lands on the next rising edge; returns 1 time unit after it
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    bus.daddr  = addr;
    bus.dwdata = data;
    bus.dwe    = we;
    @(posedge clk);
    #1;
    bus.dwe   = 4'h0;
    bus.daddr = STATUS;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.daddr = addr;
    #1;
    check(name, bus.drdata, exp);
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) exp_q.push_back(b[i]);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
  endtask

  // scoreboard: one expected uart_tx level per clock cycle, busy must hold throughout
  task automatic run_stream();
    logic [0:0] e;
    bus.dwe   = 4'h0;
    bus.daddr = STATUS;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx_bit", {31'b0, uart_tx}, {31'b0, e});
      check("busy_in_frame", {31'b0, bus.drdata[7]}, 32'd1);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    bus.daddr  = 32'h2000_0000;
    bus.dwdata = 32'h0;
    bus.dwe    = 4'h0;

    vecs[0]  = '{32'h10,        32'hDEAD_BEEF, 4'hF, 32'h10,        32'hDEAD_BEEF};
    vecs[1]  = '{32'h10,        32'h0055_0000, 4'h4, 32'h10,        32'hDE55_BEEF};
    vecs[2]  = '{32'h14,        32'h1234_5678, 4'hF, 32'h14,        32'h1234_5678};
    vecs[3]  = '{32'h14,        32'h0000_AB00, 4'h2, 32'h14,        32'h1234_AB78};
    vecs[4]  = '{32'h14,        32'hCD00_0000, 4'h8, 32'h14,        32'hCD34_AB78};
    vecs[5]  = '{32'h14,        32'h0000_00EF, 4'h1, 32'h14,        32'hCD34_ABEF};
    vecs[6]  = '{32'h14,        32'hFFFF_FFFF, 4'h0, 32'h14,        32'hCD34_ABEF};
    vecs[7]  = '{32'h0,         32'h0BAD_C0DE, 4'hF, 32'h0,         32'h0BAD_C0DE};
    vecs[8]  = '{32'hFFC,       32'hCAFE_F00D, 4'hF, 32'hFFC,       32'hCAFE_F00D};
    vecs[9]  = '{32'h1000,      32'h1111_1111, 4'hF, 32'h0,         32'h0BAD_C0DE};
    vecs[10] = '{32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 32'h2000_0000, 32'h0};
    vecs[11] = '{32'h2000_0000, 32'h0,         4'h0, 32'h1000,      32'h0};
    vecs[12] = '{32'h2000_0000, 32'h0,         4'h0, TXDATA,        32'h0};
    vecs[13] = '{32'h2000_0000, 32'h0,         4'h0, STATUS,        32'h010};
    vecs[14] = '{32'h4000_000C, 32'hFFFF_FFFF, 4'hF, 32'h4000_000C, 32'h0};
    vecs[15] = '{32'h2000_0000, 32'h0,         4'h0, 32'h12,        32'hDE55_BEEF};

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_state", {30'b0, fsm_state}, 32'd0);
`ifdef UART_IRQ_EN
    check("reset_irq", {31'b0, uart_irq}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    read_check("reset_status", STATUS, 32'h010);

    // RAM lanes and address decode
    for (int v = 0; v < 16; v++) begin
      do_write(vecs[v].waddr, vecs[v].wdata, vecs[v].we);
      read_check($sformatf("vec%0d", v), vecs[v].raddr, vecs[v].exp);
    end

    // single frame, 0xA5
    do_write(TXDATA, 32'hA5, 4'h1);
    check("push_idle_tx", {31'b0, uart_tx}, 32'd1);
    read_check("push_status", STATUS, 32'h001);
    push_frame(8'hA5);
    @(posedge clk);
    #1;
    run_stream();
    @(posedge clk);
    #1;
    read_check("frame_done_status", STATUS, 32'h010);
    check("frame_done_tx", {31'b0, uart_tx}, 32'd1);

    // overflow: six back-to-back pushes, 0x06 dropped
    for (int b = 1; b <= 6; b++) do_write(TXDATA, 32'(b), 4'h1);
    read_check("ovf_status", STATUS, 32'h1C4);
    for (int b = 1; b <= 5; b++) push_frame(8'(b));
    for (int k = 0; k < 4; k++) void'(exp_q.pop_front());
    run_stream();
    @(posedge clk);
    #1;
    read_check("ovf_sticky", STATUS, 32'h110);
    do_write(STATUS, 32'h100, 4'h1);
    read_check("ovf_cleared", STATUS, 32'h010);

    // push into a full FIFO on the same edge as the STOP-end pop
    do_write(TXDATA, 32'hA0, 4'h1);
    do_write(TXDATA, 32'hB1, 4'h1);
    do_write(TXDATA, 32'hC2, 4'h1);
    do_write(TXDATA, 32'hD3, 4'h1);
    do_write(TXDATA, 32'hE4, 4'h1);
    read_check("full_status", STATUS, 32'h0C4);
    repeat (36) @(posedge clk);
    #1;
    check("last_stop_tx", {31'b0, uart_tx}, 32'd1);
    do_write(TXDATA, 32'hF5, 4'h1);
    read_check("full_accept_status", STATUS, 32'h0C4);
    push_frame(8'hB1);
    push_frame(8'hC2);
    push_frame(8'hD3);
    push_frame(8'hE4);
    push_frame(8'hF5);
    run_stream();
    @(posedge clk);
    #1;
    read_check("full_drained_status", STATUS, 32'h010);

    // reset in the middle of a frame
    do_write(32'h20, 32'h1357_9BDF, 4'hF);
    do_write(TXDATA, 32'hA5, 4'h1);
    do_write(TXDATA, 32'h3C, 4'h1);
    repeat (9) @(posedge clk);
    #1;
    check("midframe_tx_low", {31'b0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, uart_tx}, 32'd1);
    check("async_reset_state", {30'b0, fsm_state}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    read_check("post_reset_status", STATUS, 32'h010);
    read_check("post_reset_ram", 32'h20, 32'h1357_9BDF);
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_idle_tx", {31'b0, uart_tx}, 32'd1);
    read_check("post_reset_idle_status", STATUS, 32'h010);

`ifdef UART_IRQ_EN
    do_write(IRQCTL, 32'h1, 4'h1);
    check("irq_not_yet", {31'b0, uart_irq}, 32'd0);
    read_check("irqctl_read", IRQCTL, 32'h1);
    @(posedge clk);
    #1;
    check("irq_rise", {31'b0, uart_irq}, 32'd1);
    do_write(TXDATA, 32'h33, 4'h1);
    check("irq_push_edge", {31'b0, uart_irq}, 32'd1);
    for (int c = 1; c <= 41; c++) begin
      @(posedge clk);
      #1;
      check("irq_low_in_frame", {31'b0, uart_irq}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("irq_rise_after_frame", {31'b0, uart_irq}, 32'd1);
    do_write(IRQCTL, 32'h0, 4'h1);
    read_check("irqctl_cleared", IRQCTL, 32'h0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check("irq_disabled", {31'b0, uart_irq}, 32'd0);
      @(posedge clk);
      #1;
    end
`else
    do_write(IRQCTL, 32'h1, 4'h1);
    read_check("irqctl_absent", IRQCTL, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
